// File: rtl/sparc_ifu_parchk16.sv
// rtl/sparc_ifu_parchk16.sv - IFU 16-bit receive-side parity checker with first-error log and saturating counter
// Optional feature macro: SPARC_IFU_PARCHK_INJ_EN (adds inj_err to flip data bit 0 on accepted beats)
module sparc_ifu_parchk16 #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [15:0]       in_data,
    input  logic              in_par,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [15:0]       out_data,
    output logic              out_perr,
    output logic              err_vld,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       err_data,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr_err
`ifdef SPARC_IFU_PARCHK_INJ_EN
    ,
    input  logic              inj_err
`endif
);

    logic        accept;
    logic [15:0] data_chk;
    logic        mismatch;
    logic        logged;

    // Ready depends only on stage occupancy and downstream ready, never on in_vld
    assign in_rdy = ~out_vld | out_rdy;
    assign accept = in_vld & in_rdy;

`ifdef SPARC_IFU_PARCHK_INJ_EN
    // Injected error flips bit 0 before the check so it is seen as a real fault
    assign data_chk = {in_data[15:1], in_data[0] ^ (inj_err & accept)};
`else
    assign data_chk = in_data;
`endif

    assign mismatch = (^data_chk) ^ in_par;
    assign logged   = accept & mismatch;

    // Single pipeline stage: load on accept, otherwise drain when downstream takes the beat
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            out_vld  <= 1'b0;
            out_data <= 16'h0000;
            out_perr <= 1'b0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_data <= data_chk;
            out_perr <= mismatch;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

    // Error log updates at acceptance so a stalled beat is counted once; a new error beats clr_err
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            err_vld  <= 1'b0;
            err_addr <= '0;
            err_data <= 16'h0000;
            err_cnt  <= '0;
        end else if (logged) begin
            err_vld <= 1'b1;
            if (clr_err || !err_vld) begin
                err_addr <= in_addr;
                err_data <= data_chk;
            end
            if (clr_err) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else if (clr_err) begin
            err_vld <= 1'b0;
            err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_parchk16.sv
// tb/tb_sparc_ifu_parchk16.sv - directed table-driven bench for sparc_ifu_parchk16
module tb_sparc_ifu_parchk16;

    logic        rclk;
    logic        arst_l;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_data;
    logic        in_par;
    logic [7:0]  in_addr;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_data;
    logic        out_perr;
    logic        err_vld;
    logic [7:0]  err_addr;
    logic [15:0] err_data;
    logic [3:0]  err_cnt;
    logic        clr_err;
`ifdef SPARC_IFU_PARCHK_INJ_EN
    logic        inj_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sparc_ifu_parchk16 #(.ADDR_W(8), .CNT_W(4)) dut (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_par   (in_par),
        .in_addr  (in_addr),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_perr (out_perr),
        .err_vld  (err_vld),
        .err_addr (err_addr),
        .err_data (err_data),
        .err_cnt  (err_cnt),
        .clr_err  (clr_err)
`ifdef SPARC_IFU_PARCHK_INJ_EN
        ,
        .inj_err  (inj_err)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic        vld;
        logic [15:0] data;
        logic        par;
        logic [7:0]  addr;
        logic        ordy;
        logic        clr;
        logic        e_rdy;
        logic        e_ovld;
        logic [15:0] e_odata;
        logic        e_perr;
        logic        e_evld;
        logic [7:0]  e_eaddr;
        logic [15:0] e_edata;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on negedge, check in_rdy before the edge, check registered outputs 1ns after it
    task automatic step(input vec_t v, input string name);
        @(negedge rclk);
        in_vld  = v.vld;
        in_data = v.data;
        in_par  = v.par;
        in_addr = v.addr;
        out_rdy = v.ordy;
        clr_err = v.clr;
        #1;
        chk({name, ".in_rdy"}, in_rdy, v.e_rdy);
        @(posedge rclk);
        #1;
        chk({name, ".out_vld"}, out_vld, v.e_ovld);
        if (v.e_ovld) begin
            chk({name, ".out_data"}, out_data, v.e_odata);
            chk({name, ".out_perr"}, out_perr, v.e_perr);
        end
        chk({name, ".err_vld"}, err_vld, v.e_evld);
        chk({name, ".err_addr"}, err_addr, v.e_eaddr);
        chk({name, ".err_data"}, err_data, v.e_edata);
        chk({name, ".err_cnt"}, err_cnt, v.e_cnt);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".out_vld"}, out_vld, 0);
        chk({name, ".out_data"}, out_data, 0);
        chk({name, ".out_perr"}, out_perr, 0);
        chk({name, ".err_vld"}, err_vld, 0);
        chk({name, ".err_addr"}, err_addr, 0);
        chk({name, ".err_data"}, err_data, 0);
        chk({name, ".err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        vec_t v;
        logic [15:0] d;

        //          vld  data      par  addr   ordy clr  rdy  ovld odata     perr evld eaddr  edata     cnt
        vt[0] = '{1'b1, 16'h0001, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 8'h00, 16'h0000, 4'h0};
        vt[1] = '{1'b1, 16'h0003, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 8'h22, 16'h0003, 4'h1};
        vt[2] = '{1'b1, 16'h0007, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b1, 8'h22, 16'h0003, 4'h2};
        vt[3] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h22, 16'h0003, 4'h2};
        vt[4] = '{1'b1, 16'hFFFF, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 8'h22, 16'h0003, 4'h2};
        vt[5] = '{1'b1, 16'h0005, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 8'h22, 16'h0003, 4'h2};
        vt[6] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h22, 16'h0003, 4'h2};

        arst_l  = 1'b0;
        in_vld  = 1'b0;
        in_data = 16'h0000;
        in_par  = 1'b0;
        in_addr = 8'h00;
        out_rdy = 1'b1;
        clr_err = 1'b0;
`ifdef SPARC_IFU_PARCHK_INJ_EN
        inj_err = 1'b0;
`endif
        repeat (3) @(posedge rclk);
        #1;
        chk_all_zero("reset");
        @(negedge rclk);
        arst_l = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(vt[i], $sformatf("vec%0d", i));
        end

        // Saturation: 20 bad beats, counter climbs from 2 and sticks at F, first address kept
        for (int i = 0; i < 20; i++) begin
            v = '{1'b1, 16'h0003, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 8'h22, 16'h0003,
                  (3 + i > 15) ? 4'hF : 4'(3 + i)};
            step(v, $sformatf("sat%0d", i));
        end

        // clr_err alone: valid and count clear, stale address/data remain
        v = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h22, 16'h0003, 4'h0};
        step(v, "clr_alone");

        // Stall: bad beat enters, then downstream stalls with a pending (also bad) input for 5 cycles
        v = '{1'b1, 16'h0001, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 8'h55, 16'h0001, 4'h1};
        step(v, "stall_load");
        for (int i = 0; i < 5; i++) begin
            v = '{1'b1, 16'h0002, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 8'h55, 16'h0001, 4'h1};
            step(v, $sformatf("stall%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            d = 16'h0100 + 16'(i);
            v = '{1'b1, d, ^d, 8'(i), 1'b1, 1'b0, 1'b1, 1'b1, d, 1'b0, 1'b1, 8'h55, 16'h0001, 4'h1};
            step(v, $sformatf("stream%0d", i));
        end
        v = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h55, 16'h0001, 4'h1};
        step(v, "drain");

        // Bring the count to 5, then clr_err collides with a new bad beat: new error wins
        for (int i = 0; i < 4; i++) begin
            v = '{1'b1, 16'h0003, 1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 8'h55, 16'h0001,
                  4'(2 + i)};
            step(v, $sformatf("pre_clr%0d", i));
        end
        v = '{1'b1, 16'h0003, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 8'h44, 16'h0003, 4'h1};
        step(v, "clr_collide");
        v = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h44, 16'h0003, 4'h0};
        step(v, "clr_after");
        clr_err = 1'b0;

`ifdef SPARC_IFU_PARCHK_INJ_EN
        // Injection turns a clean zero word into a flagged 0001
        @(negedge rclk);
        inj_err = 1'b1;
        v = '{1'b1, 16'h0000, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 8'h12, 16'h0001, 4'h1};
        step(v, "inj");
        v = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h12, 16'h0001, 4'h1};
        step(v, "inj_idle");
        inj_err = 1'b0;
`endif

        // Reset mid-stream with a stalled bad beat in the stage
        v = '{1'b1, 16'h0003, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 8'h99, 16'h0003, 4'h1};
`ifdef SPARC_IFU_PARCHK_INJ_EN
        v.e_eaddr = 8'h12;
        v.e_edata = 16'h0001;
        v.e_cnt   = 4'h2;
`endif
        step(v, "pre_rst");
        #2;
        arst_l = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge rclk);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        arst_l  = 1'b1;
        v = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 4'h0};
        step(v, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
